coin_change_dispenser: RTL and testbench
========================================

// Module: coin_change_dispenser
// PURPOSE
//  Back end of the vending machine's change output: takes a 7-bit change amount and pays it out as individual coins to a coin hopper.
//  - Denomination choice: greedy, largest coin first.
//  - Handshake: one coin per valid/ack exchange with the hopper.
//  - Inventory: tracks coins left per denomination; reports any amount it could not pay.
//  - Integration: i_change_valid <= o_dispense_product, i_change_amount <= o_return_change of the vending FSM.
// PARAMETERS
//  DENOM_0     7'd10  largest coin value (sel 2'd0)
//  DENOM_1     7'd5   coin value, sel 2'd1
//  DENOM_2     7'd2   coin value, sel 2'd2
//  DENOM_3     7'd1   smallest coin value, sel 2'd3; must be 1; DENOM_0>DENOM_1>DENOM_2>DENOM_3
//  COUNT_W     8      width of each per-denomination inventory counter
//  INIT_COUNT  8'd20  coins loaded per denomination at reset/refill
// PORTS
//  i_clk            in   1   clock
//  i_rst            in   1   reset; asynchronous, active-high
//  i_change_valid   in   1   change request strobe
//  i_change_amount  in   7   change to pay; sampled with i_change_valid
//  i_refill         in   1   reload all counters to INIT_COUNT (honoured in IDLE only)
//  o_change_ready   out  1   1 in IDLE only
//  o_coin_valid     out  1   coin request to hopper
//  o_coin_sel       out  2   denomination index of requested coin
//  i_coin_ack       in   1   hopper has ejected the requested coin
//  o_busy           out  1   1 in any state other than IDLE
//  o_done           out  1   1-cycle pulse at end of each accepted request
//  o_shortfall      out  7   unpaid remainder; valid with o_done, held until next accept
//  o_overrun        out  1   1-cycle pulse: i_change_valid seen while not ready (request dropped)
//  o_state          out  3   current state code
// BEHAVIOUR
//  Reset values: state=IDLE, all counters=INIT_COUNT, remaining=0, o_shortfall=0. All pulse/valid outputs = 0.
//  Reset mid-operation: any pending coin request is abandoned.
//  States: IDLE=0, SELECT=1, ISSUE=2, DONE=3, SHORT=4.
//  IDLE
//   - i_change_valid: latch amount into remaining; clear o_shortfall; -> SELECT.
//   - Else i_refill: all counters <= INIT_COUNT.
//  SELECT (1 cycle)
//   - remaining==0 -> DONE.
//   - Else latch sel = lowest index k with DENOM_k<=remaining and count_k!=0 -> ISSUE.
//   - None found -> SHORT.
//  ISSUE
//   - o_coin_valid=1; o_coin_sel held stable until ack.
//   - i_coin_ack: remaining -= DENOM_sel; count_sel -= 1; -> SELECT.
//   - Ack is ignored outside ISSUE.
//  DONE (1 cycle): o_done=1, o_shortfall=0 -> IDLE.
//  SHORT (1 cycle): o_done=1, o_shortfall=remaining -> IDLE.
//  Latency: accept->o_done = 2 cycles for amount 0; otherwise sum over coins of (1 + ack wait) + 2 cycles; immediate ack = 2 cycles/coin.
//  Arithmetic: remaining never underflows, since only DENOM<=remaining is issued; counters never go below 0.
//  Overrun: i_change_valid in any non-IDLE state -> o_overrun pulse; current job is unaffected.
//  Refill outside IDLE is ignored.
//  Simultaneous i_change_valid+i_refill in IDLE: both take effect; SELECT sees the refilled counts.
// STRUCTURE
//  Package vending_pkg:
//   - dispenser state localparams
//   - coin_sel encoding
//   - default denomination values, shared with the vending FSM price constants
//  Sub-module coin_denom_picker (combinational):
//   - inputs: remaining, four counts
//   - outputs: found, sel[1:0]
//  Top holds the FSM, the remaining register, counters and outputs.
// TESTING
//  1 amount 37, ack same cycle as valid -> sel 0,0,0,1,2; o_done with shortfall 0; count0=17.
//  2 amount 0 -> no o_coin_valid; o_done 2 cycles after accept; shortfall 0.
//  3 ack delayed 3 cycles on 2nd coin of amount 15 -> valid/sel=1 stable for 4 cycles; no extra coin.
//  4 INIT_COUNT=1, amount 30 -> coins 10,5,2,1 then o_done with shortfall 12.
//    Then i_refill in IDLE, amount 3 -> coins 2,1, shortfall 0.
//  5 i_change_valid during ISSUE -> o_overrun pulse; original job completes unchanged.
//  6 i_rst asserted mid-ISSUE -> next cycle state 0, o_coin_valid=0, counters at INIT_COUNT.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: dispenser state codes, coin selector
// encoding and the default coin denominations used by both change and pricing logic.
package vending_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_SHORT  = 3'd4
    } disp_state_t;

    localparam logic [1:0] SEL_D0 = 2'd0;
    localparam logic [1:0] SEL_D1 = 2'd1;
    localparam logic [1:0] SEL_D2 = 2'd2;
    localparam logic [1:0] SEL_D3 = 2'd3;

    localparam logic [6:0] COIN_10 = 7'd10;
    localparam logic [6:0] COIN_5  = 7'd5;
    localparam logic [6:0] COIN_2  = 7'd2;
    localparam logic [6:0] COIN_1  = 7'd1;

    function automatic logic [6:0] denom_value(
        input logic [1:0] sel,
        input logic [6:0] d0,
        input logic [6:0] d1,
        input logic [6:0] d2,
        input logic [6:0] d3
    );
        case (sel)
            SEL_D0:  return d0;
            SEL_D1:  return d1;
            SEL_D2:  return d2;
            default: return d3;
        endcase
    endfunction

endpackage

// File: rtl/coin_denom_picker.sv
// Greedy coin chooser: picks the largest denomination that fits the remaining
// amount and is still in stock.
module coin_denom_picker
    import vending_pkg::*;
#(
    parameter logic [6:0]  DENOM_0 = COIN_10,
    parameter logic [6:0]  DENOM_1 = COIN_5,
    parameter logic [6:0]  DENOM_2 = COIN_2,
    parameter logic [6:0]  DENOM_3 = COIN_1,
    parameter int unsigned COUNT_W = 8
) (
    input  logic [6:0]         remaining,
    input  logic [COUNT_W-1:0] counts [4],
    output logic               found,
    output logic [1:0]         sel
);

    localparam logic [6:0] DENOM_TAB [4] = '{DENOM_0, DENOM_1, DENOM_2, DENOM_3};

    logic [3:0] cand;

    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign cand[gi] = (DENOM_TAB[gi] <= remaining) && (counts[gi] != '0);
    end

    // Index 0 is the largest coin, so the lowest set candidate wins.
    always_comb begin
        found = |cand;
        sel   = SEL_D3;
        for (int k = 3; k >= 0; k--) begin
            if (cand[k]) sel = 2'(k);
        end
    end

endmodule

// File: rtl/coin_change_dispenser.sv
// Pays a change amount out one coin at a time over a valid/ack hopper handshake,
// tracking per-denomination stock and reporting any amount left unpaid.
module coin_change_dispenser
    import vending_pkg::*;
#(
    parameter logic [6:0]          DENOM_0    = COIN_10,
    parameter logic [6:0]          DENOM_1    = COIN_5,
    parameter logic [6:0]          DENOM_2    = COIN_2,
    parameter logic [6:0]          DENOM_3    = COIN_1,
    parameter int unsigned         COUNT_W    = 8,
    parameter logic [COUNT_W-1:0]  INIT_COUNT = COUNT_W'(20)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_change_valid,
    input  logic [6:0] i_change_amount,
    input  logic       i_refill,
    output logic       o_change_ready,
    output logic       o_coin_valid,
    output logic [1:0] o_coin_sel,
    input  logic       i_coin_ack,
    output logic       o_busy,
    output logic       o_done,
    output logic [6:0] o_shortfall,
    output logic       o_overrun,
    output logic [2:0] o_state
);

    disp_state_t        state_reg, state_next;
    logic [6:0]         remaining_reg;
    logic [1:0]         sel_reg;
    logic [COUNT_W-1:0] count_reg [4];
    logic [6:0]         shortfall_reg;
    logic               overrun_reg;

    logic               pick_found;
    logic [1:0]         pick_sel;

    coin_denom_picker #(
        .DENOM_0 (DENOM_0),
        .DENOM_1 (DENOM_1),
        .DENOM_2 (DENOM_2),
        .DENOM_3 (DENOM_3),
        .COUNT_W (COUNT_W)
    ) u_picker (
        .remaining (remaining_reg),
        .counts    (count_reg),
        .found     (pick_found),
        .sel       (pick_sel)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_change_valid) state_next = ST_SELECT;
            end
            ST_SELECT: begin
                if (remaining_reg == '0) state_next = ST_DONE;
                else if (pick_found)     state_next = ST_ISSUE;
                else                     state_next = ST_SHORT;
            end
            ST_ISSUE: begin
                if (i_coin_ack) state_next = ST_SELECT;
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_SHORT: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_change_ready = (state_reg == ST_IDLE);
        o_busy         = (state_reg != ST_IDLE);
        o_coin_valid   = (state_reg == ST_ISSUE);
        o_coin_sel     = sel_reg;
        o_done         = (state_reg == ST_DONE) || (state_reg == ST_SHORT);
        // The shortfall must be visible in the same cycle as o_done.
        o_shortfall    = (state_reg == ST_SHORT) ? remaining_reg : shortfall_reg;
        o_overrun      = overrun_reg;
        o_state        = state_reg;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            remaining_reg <= '0;
            sel_reg       <= SEL_D0;
            shortfall_reg <= '0;
            overrun_reg   <= 1'b0;
            for (int k = 0; k < 4; k++) count_reg[k] <= INIT_COUNT;
        end else begin
            overrun_reg <= i_change_valid && (state_reg != ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    if (i_change_valid) begin
                        remaining_reg <= i_change_amount;
                        shortfall_reg <= '0;
                    end
                    // Refill is independent of the request so SELECT sees fresh stock.
                    if (i_refill) begin
                        for (int k = 0; k < 4; k++) count_reg[k] <= INIT_COUNT;
                    end
                end
                ST_SELECT: begin
                    sel_reg <= pick_sel;
                end
                ST_ISSUE: begin
                    if (i_coin_ack && (count_reg[sel_reg] != '0)) begin
                        remaining_reg      <= remaining_reg -
                                              denom_value(sel_reg, DENOM_0, DENOM_1, DENOM_2, DENOM_3);
                        count_reg[sel_reg] <= count_reg[sel_reg] - COUNT_W'(1);
                    end
                end
                ST_DONE:  shortfall_reg <= '0;
                ST_SHORT: shortfall_reg <= remaining_reg;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed checks of the change dispenser: greedy coin order, handshake stalls,
// stock exhaustion with shortfall, refill, overrun and mid-job reset.
module tb_coin_change_dispenser;

    logic       clk = 1'b0;
    logic       rst;

    logic       a_valid, a_refill, a_ack, a_block;
    logic [6:0] a_amount;
    logic       a_ready, a_coin_valid, a_busy, a_done, a_overrun;
    logic [1:0] a_coin_sel;
    logic [6:0] a_shortfall;
    logic [2:0] a_state;

    logic       b_valid, b_refill, b_ack;
    logic [6:0] b_amount;
    logic       b_ready, b_coin_valid, b_busy, b_done, b_overrun;
    logic [1:0] b_coin_sel;
    logic [6:0] b_shortfall;
    logic [2:0] b_state;

    int total = 0;
    int bad   = 0;

    int          a_n = 0, b_n = 0, a_sel1 = 0;
    logic [31:0] a_log = 0, b_log = 0;

    always #5 clk = ~clk;

    // Hopper models: A can be stalled, B always acks immediately.
    assign a_ack = a_coin_valid & ~a_block;
    assign b_ack = b_coin_valid;

    coin_change_dispenser dut_a (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_change_valid  (a_valid),
        .i_change_amount (a_amount),
        .i_refill        (a_refill),
        .o_change_ready  (a_ready),
        .o_coin_valid    (a_coin_valid),
        .o_coin_sel      (a_coin_sel),
        .i_coin_ack      (a_ack),
        .o_busy          (a_busy),
        .o_done          (a_done),
        .o_shortfall     (a_shortfall),
        .o_overrun       (a_overrun),
        .o_state         (a_state)
    );

    coin_change_dispenser #(.INIT_COUNT(8'd1)) dut_b (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_change_valid  (b_valid),
        .i_change_amount (b_amount),
        .i_refill        (b_refill),
        .o_change_ready  (b_ready),
        .o_coin_valid    (b_coin_valid),
        .o_coin_sel      (b_coin_sel),
        .i_coin_ack      (b_ack),
        .o_busy          (b_busy),
        .o_done          (b_done),
        .o_shortfall     (b_shortfall),
        .o_overrun       (b_overrun),
        .o_state         (b_state)
    );

    always @(negedge clk) begin
        if (a_coin_valid && a_ack) begin
            a_log = (a_log << 2) | 32'(a_coin_sel);
            a_n   = a_n + 1;
        end
        if (a_coin_valid && a_coin_sel == 2'd1) a_sel1 = a_sel1 + 1;
        if (b_coin_valid && b_ack) begin
            b_log = (b_log << 2) | 32'(b_coin_sel);
            b_n   = b_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic start_a(input logic [6:0] amt);
        a_n = 0; a_log = 0; a_sel1 = 0;
        @(posedge clk); #1 a_valid = 1'b1; a_amount = amt;
        @(posedge clk); #1 a_valid = 1'b0;
    endtask

    task automatic start_b(input logic [6:0] amt, input logic refill);
        b_n = 0; b_log = 0;
        @(posedge clk); #1 b_valid = 1'b1; b_amount = amt; b_refill = refill;
        @(posedge clk); #1 b_valid = 1'b0; b_refill = 1'b0;
    endtask

    task automatic wait_done_a(output int lat, output logic [6:0] sf);
        lat = 0; sf = 'x;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); lat++;
            if (a_done) begin sf = a_shortfall; return; end
        end
        check("a_done_timeout", 0, 1);
    endtask

    task automatic wait_done_b(output logic [6:0] sf);
        sf = 'x;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b_done) begin sf = b_shortfall; return; end
        end
        check("b_done_timeout", 0, 1);
    endtask

    task automatic wait_coin_a();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_coin_valid) return;
        end
        check("a_coin_timeout", 0, 1);
    endtask

    int         lat;
    logic [6:0] sf;

    initial begin
        rst = 1'b1; a_block = 1'b0;
        a_valid = 0; a_refill = 0; a_amount = 0;
        b_valid = 0; b_refill = 0; b_amount = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_state",     32'(a_state), 0);
        check("rst_ready",     32'(a_ready), 1);
        check("rst_busy",      32'(a_busy), 0);
        check("rst_coin_valid",32'(a_coin_valid), 0);
        check("rst_done",      32'(a_done), 0);
        check("rst_shortfall", 32'(a_shortfall), 0);
        check("rst_overrun",   32'(a_overrun), 0);
        check("rst_count3",    32'(dut_a.count_reg[3]), 20);
        check("rst_b_count0",  32'(dut_b.count_reg[0]), 1);

        // 37 = 10+10+10+5+2 with immediate ack: 5 coins * 2 + 2 cycles
        start_a(7'd37);
        wait_done_a(lat, sf);
        check("t1_latency",  32'(lat), 12);
        check("t1_ncoins",   32'(a_n), 5);
        check("t1_sels",     a_log, 32'h006);
        check("t1_shortfall",32'(sf), 0);
        check("t1_count0",   32'(dut_a.count_reg[0]), 17);
        check("t1_count2",   32'(dut_a.count_reg[2]), 19);

        start_a(7'd0);
        wait_done_a(lat, sf);
        check("t2_latency",  32'(lat), 2);
        check("t2_ncoins",   32'(a_n), 0);
        check("t2_shortfall",32'(sf), 0);

        // 15 = 10+5, the 5 coin is held off for 3 cycles
        a_block = 1'b1;
        start_a(7'd15);
        wait_coin_a();
        check("t3_first_sel", 32'(a_coin_sel), 0);
        a_block = 1'b0;
        @(posedge clk); #1 a_block = 1'b1;
        wait_coin_a();
        repeat (3) @(posedge clk);
        #1 a_block = 1'b0;
        wait_done_a(lat, sf);
        check("t3_sel1_cycles", 32'(a_sel1), 4);
        check("t3_ncoins",      32'(a_n), 2);
        check("t3_sels",        a_log, 32'h1);
        check("t3_shortfall",   32'(sf), 0);

        // INIT_COUNT=1: 30 -> 10,5,2,1 and 12 unpaid
        start_b(7'd30, 1'b0);
        wait_done_b(sf);
        check("t4_ncoins",    32'(b_n), 4);
        check("t4_sels",      b_log, 32'h1B);
        check("t4_shortfall", 32'(sf), 12);
        @(negedge clk);
        check("t4_sf_hold",   32'(b_shortfall), 12);
        check("t4_done_pulse",32'(b_done), 0);
        // Empty stock, refill together with the request: 3 -> 2,1
        start_b(7'd3, 1'b1);
        wait_done_b(sf);
        check("t4r_ncoins",   32'(b_n), 2);
        check("t4r_sels",     b_log, 32'hB);
        check("t4r_shortfall",32'(sf), 0);

        a_block = 1'b1;
        start_a(7'd5);
        wait_coin_a();
        check("t5_state_issue", 32'(a_state), 2);
        check("t5_busy",        32'(a_busy), 1);
        @(posedge clk); #1 a_valid = 1'b1; a_amount = 7'd99;
        @(negedge clk);
        check("t5_overrun_early", 32'(a_overrun), 0);
        @(posedge clk); #1 a_valid = 1'b0;
        @(negedge clk);
        check("t5_overrun",     32'(a_overrun), 1);
        check("t5_sel_stable",  32'(a_coin_sel), 1);
        @(negedge clk);
        check("t5_overrun_end", 32'(a_overrun), 0);
        a_block = 1'b0;
        wait_done_a(lat, sf);
        check("t5_ncoins",    32'(a_n), 1);
        check("t5_shortfall", 32'(sf), 0);
        check("t5_count1",    32'(dut_a.count_reg[1]), 17);

        a_block = 1'b1;
        start_a(7'd10);
        wait_coin_a();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("t6_state",      32'(a_state), 0);
        check("t6_coin_valid", 32'(a_coin_valid), 0);
        check("t6_count0",     32'(dut_a.count_reg[0]), 20);
        check("t6_b_count0",   32'(dut_b.count_reg[0]), 1);
        @(posedge clk); #1 rst = 1'b0; a_block = 1'b0;
        @(negedge clk);
        check("t6_ready",      32'(a_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
